// File: rtl/pll_reset_seq.sv
// pll_reset_seq
//
// Generates the system reset for the clock domain driven by a PLL. The
// asynchronous lock indicator is synchronised, filtered for stability, and
// then followed by a fixed hold period before reset is released. Losing lock
// while running re-asserts reset. A soft request re-pulses reset for the
// hold period only.
//
// Parameters:
//   SYNC_STAGES   - depth of the pll_locked synchroniser (2..4)
//   FILTER_CYCLES - cycles synchronised lock must stay high before hold (1..65535)
//   HOLD_CYCLES   - cycles reset is held after the filter passes (1..65535)
//
// Ports:
//   clk             - PLL output clock
//   rst             - asynchronous active-high reset (power-on / button)
//   pll_locked      - PLL lock indicator, asynchronous to clk
//   soft_rst_req    - single-cycle synchronous request to re-pulse sys_rst
//   sys_rst         - registered active-high reset for the clk domain
//   sys_rst_n       - registered complement of sys_rst
//   ready           - high exactly while the sequencer is in RUN
//   lock_loss_count - saturating count of lock-loss events
//
// Build option:
//   PLL_RESET_SEQ_LOSS_COUNT_EN - when defined, lock_loss_count counts
//   RUN-to-WAIT_LOCK transitions (saturating at 255); when undefined it is
//   tied to zero and no counter flops exist.

module pll_reset_seq #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16,
    parameter int HOLD_CYCLES   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_rst_req,
    output logic       sys_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [7:0] lock_loss_count
);

    localparam int CNT_MAX = (FILTER_CYCLES > HOLD_CYCLES) ? FILTER_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] FILTER    = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [1:0]             state;
    logic [1:0]             next_state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       next_cnt;

    // pll_locked is sampled only here; the last stage is the only lock
    // signal the rest of the design sees.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Lock loss is checked first in every locked state so it always wins
    // over a coincident soft request.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state = FILTER;
                    next_cnt   = '0;
                end
            end
            FILTER: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                end else if (cnt == FILTER_LAST) begin
                    next_state = HOLD;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                end else if (cnt == HOLD_LAST) begin
                    next_state = RUN;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                end else if (soft_rst_req) begin
                    next_state = HOLD;
                    next_cnt   = '0;
                end
            end
            default: begin
                next_state = WAIT_LOCK;
                next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Outputs are registered from next_state so they move on the same edge
    // as the state itself rather than one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sys_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
        end else begin
            sys_rst   <= (next_state != RUN);
            sys_rst_n <= (next_state == RUN);
            ready     <= (next_state == RUN);
        end
    end

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_cnt;

    // A lock-loss event is exactly a RUN-to-WAIT_LOCK transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt <= 8'd0;
        end else if ((state == RUN) && !locked_s && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

    assign lock_loss_count = loss_cnt;
`else
    assign lock_loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq
//
// Bench for pll_reset_seq. The main instance uses the default parameters;
// a second instance with single-cycle filter and hold is used where many
// lock-loss events are needed quickly. Expected values follow the
// PLL_RESET_SEQ_LOSS_COUNT_EN setting of the build.

module tb_pll_reset_seq;

    localparam int SYNC   = 2;
    localparam int FILT   = 16;
    localparam int HOLDC  = 256;
    localparam int REL    = SYNC + FILT + HOLDC + 1;
    localparam int F_REL  = 2 + 1 + 1 + 1;

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       sys_rst;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] lock_loss_count;

    logic       fast_locked = 1'b0;
    logic       fast_soft = 1'b0;
    logic       fast_sys_rst;
    logic       fast_sys_rst_n;
    logic       fast_ready;
    logic [7:0] fast_count;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int loss_events = 0;

    always #5 clk = ~clk;

    pll_reset_seq #(
        .SYNC_STAGES  (SYNC),
        .FILTER_CYCLES(FILT),
        .HOLD_CYCLES  (HOLDC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .soft_rst_req   (soft_rst_req),
        .sys_rst        (sys_rst),
        .sys_rst_n      (sys_rst_n),
        .ready          (ready),
        .lock_loss_count(lock_loss_count)
    );

    pll_reset_seq #(
        .SYNC_STAGES  (2),
        .FILTER_CYCLES(1),
        .HOLD_CYCLES  (1)
    ) dut_fast (
        .clk            (clk),
        .rst            (rst),
        .pll_locked     (fast_locked),
        .soft_rst_req   (fast_soft),
        .sys_rst        (fast_sys_rst),
        .sys_rst_n      (fast_sys_rst_n),
        .ready          (fast_ready),
        .lock_loss_count(fast_count)
    );

    function automatic int exp_count(input int events);
        if (!CNT_EN) return 0;
        return (events > 255) ? 255 : events;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until sys_rst reaches level, or -1.
    task automatic wait_main(input logic level, input int limit, output int n);
        n = 0;
        while (sys_rst !== level && n < limit) begin
            tick();
            n++;
        end
        if (sys_rst !== level) n = -1;
    endtask

    task automatic wait_fast(input logic level, input int limit, output int n);
        n = 0;
        while (fast_sys_rst !== level && n < limit) begin
            tick();
            n++;
        end
        if (fast_sys_rst !== level) n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        fast_locked = 1'b0;
        loss_events = 0;
        repeat (3) tick();
        total++;
        if (sys_rst !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_sys_rst: got %b expected 1", sys_rst);
        end
        total++;
        if (sys_rst_n !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_sys_rst_n: got %b expected 0", sys_rst_n);
        end
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ready: got %b expected 0", ready);
        end
        total++;
        if (lock_loss_count !== 8'd0) begin
            bad++;
            $display("[TB] FAIL reset_count: got %0d expected 0", lock_loss_count);
        end
    endtask

    task automatic test_release();
        int n;
        int e;
        rst = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        exp_q.push_back(REL);
        wait_main(1'b0, 400, n);
        e = exp_q.pop_front();
        total++;
        if (n !== e) begin
            bad++;
            $display("[TB] FAIL release_latency: got %0d expected %0d", n, e);
        end
        total++;
        if (ready !== 1'b1 || sys_rst_n !== 1'b1) begin
            bad++;
            $display("[TB] FAIL release_outputs: got ready=%b sys_rst_n=%b expected 1/1", ready, sys_rst_n);
        end
    endtask

    task automatic test_glitch();
        int n;
        int e;
        int released;
        rst = 1'b1;
        pll_locked = 1'b0;
        loss_events = 0;
        tick();
        rst = 1'b0;
        tick();
        released = 0;
        pll_locked = 1'b1;
        repeat (10) begin
            tick();
            if (sys_rst !== 1'b1) released++;
        end
        pll_locked = 1'b0;
        repeat (5) begin
            tick();
            if (sys_rst !== 1'b1) released++;
        end
        total++;
        if (released !== 0) begin
            bad++;
            $display("[TB] FAIL glitch_no_release: got %0d released cycles expected 0", released);
        end
        pll_locked = 1'b1;
        exp_q.push_back(REL);
        wait_main(1'b0, 400, n);
        e = exp_q.pop_front();
        total++;
        if (n !== e) begin
            bad++;
            $display("[TB] FAIL glitch_release_latency: got %0d expected %0d", n, e);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        int e;
        pll_locked = 1'b0;
        loss_events++;
        exp_q.push_back(exp_count(loss_events));
        repeat (2) tick();
        total++;
        if (sys_rst !== 1'b0) begin
            bad++;
            $display("[TB] FAIL loss_edge2: got %b expected 0", sys_rst);
        end
        tick();
        total++;
        if (sys_rst !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL loss_edge3: got sys_rst=%b ready=%b expected 1/0", sys_rst, ready);
        end
        e = exp_q.pop_front();
        total++;
        if (int'(lock_loss_count) !== e) begin
            bad++;
            $display("[TB] FAIL loss_count: got %0d expected %0d", lock_loss_count, e);
        end
        pll_locked = 1'b1;
        exp_q.push_back(REL);
        wait_main(1'b0, 400, n);
        e = exp_q.pop_front();
        total++;
        if (n !== e) begin
            bad++;
            $display("[TB] FAIL loss_relock_latency: got %0d expected %0d", n, e);
        end
    endtask

    task automatic test_soft_reset();
        int n;
        int e;
        soft_rst_req = 1'b1;
        exp_q.push_back(HOLDC);
        tick();
        soft_rst_req = 1'b0;
        n = 0;
        while (sys_rst === 1'b1 && n < 400) begin
            n++;
            tick();
        end
        e = exp_q.pop_front();
        total++;
        if (n !== e) begin
            bad++;
            $display("[TB] FAIL soft_hold_cycles: got %0d expected %0d", n, e);
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL soft_back_to_run: got %b expected 1", ready);
        end
        total++;
        if (int'(lock_loss_count) !== exp_count(loss_events)) begin
            bad++;
            $display("[TB] FAIL soft_count: got %0d expected %0d", lock_loss_count, exp_count(loss_events));
        end
    endtask

    task automatic test_soft_and_loss();
        int n;
        int e;
        int released;
        pll_locked = 1'b0;
        loss_events++;
        exp_q.push_back(exp_count(loss_events));
        repeat (2) tick();
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        total++;
        if (sys_rst !== 1'b1) begin
            bad++;
            $display("[TB] FAIL both_sys_rst: got %b expected 1", sys_rst);
        end
        e = exp_q.pop_front();
        total++;
        if (int'(lock_loss_count) !== e) begin
            bad++;
            $display("[TB] FAIL both_count: got %0d expected %0d", lock_loss_count, e);
        end
        released = 0;
        repeat (300) begin
            tick();
            if (sys_rst !== 1'b1) released++;
        end
        total++;
        if (released !== 0) begin
            bad++;
            $display("[TB] FAIL both_stays_reset: got %0d released cycles expected 0", released);
        end
        pll_locked = 1'b1;
        exp_q.push_back(REL);
        wait_main(1'b0, 400, n);
        e = exp_q.pop_front();
        total++;
        if (n !== e) begin
            bad++;
            $display("[TB] FAIL both_relock_latency: got %0d expected %0d", n, e);
        end
    endtask

    task automatic test_saturation();
        int n;
        int e;
        int timeouts;
        timeouts = 0;
        for (int i = 0; i < 300; i++) begin
            fast_locked = 1'b1;
            if (i == 0) exp_q.push_back(F_REL);
            wait_fast(1'b0, 50, n);
            if (n < 0) timeouts++;
            if (i == 0) begin
                e = exp_q.pop_front();
                total++;
                if (n !== e) begin
                    bad++;
                    $display("[TB] FAIL fast_release_latency: got %0d expected %0d", n, e);
                end
            end
            fast_locked = 1'b0;
            wait_fast(1'b1, 20, n);
            if (n < 0) timeouts++;
            if (i == 9) begin
                total++;
                if (int'(fast_count) !== exp_count(10)) begin
                    bad++;
                    $display("[TB] FAIL fast_count_10: got %0d expected %0d", fast_count, exp_count(10));
                end
            end
        end
        total++;
        if (timeouts !== 0) begin
            bad++;
            $display("[TB] FAIL fast_timeouts: got %0d expected 0", timeouts);
        end
        exp_q.push_back(exp_count(300));
        e = exp_q.pop_front();
        total++;
        if (int'(fast_count) !== e) begin
            bad++;
            $display("[TB] FAIL fast_saturation: got %0d expected %0d", fast_count, e);
        end
    endtask

    task automatic test_reset_mid_hold();
        int n;
        int e;
        pll_locked = 1'b0;
        loss_events++;
        repeat (3) tick();
        pll_locked = 1'b1;
        fast_locked = 1'b1;
        repeat (120) tick();
        total++;
        if (int'(lock_loss_count) !== exp_count(loss_events) || fast_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midhold_pre: got count=%0d fast_ready=%b expected %0d/1", lock_loss_count, fast_ready, exp_count(loss_events));
        end
        #2;
        rst = 1'b1;
        loss_events = 0;
        #1;
        total++;
        if (sys_rst !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0 || lock_loss_count !== 8'd0) begin
            bad++;
            $display("[TB] FAIL midhold_async_main: got %b/%b/%b/%0d expected 1/0/0/0", sys_rst, sys_rst_n, ready, lock_loss_count);
        end
        total++;
        if (fast_sys_rst !== 1'b1 || fast_sys_rst_n !== 1'b0 || fast_ready !== 1'b0 || fast_count !== 8'd0) begin
            bad++;
            $display("[TB] FAIL midhold_async_fast: got %b/%b/%b/%0d expected 1/0/0/0", fast_sys_rst, fast_sys_rst_n, fast_ready, fast_count);
        end
        tick();
        rst = 1'b0;
        exp_q.push_back(REL);
        wait_main(1'b0, 400, n);
        e = exp_q.pop_front();
        total++;
        if (n !== e) begin
            bad++;
            $display("[TB] FAIL midhold_restart_latency: got %0d expected %0d", n, e);
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_glitch();
        test_lock_loss();
        test_soft_reset();
        test_soft_and_loss();
        test_saturation();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
- REQ-001: The module SHALL have parameter SYNC_STAGES, default 2, giving the number of synchroniser flops on pll_locked (legal range 2..4).
- REQ-002: The module SHALL have parameter FILTER_CYCLES, default 16, giving the number of consecutive cycles synchronised lock must be high before hold starts (legal range 1..65535).
- REQ-003: The module SHALL have parameter HOLD_CYCLES, default 256, giving the number of cycles reset is held after the filter passes (legal range 1..65535).
- REQ-004: Port clk, input, 1 bit: the single clock, driven by the PLL output clock.
- REQ-005: Port rst, input, 1 bit: asynchronous, active-high reset (power-on or button).
- REQ-006: Port pll_locked, input, 1 bit: PLL lock indicator, asynchronous to clk.
- REQ-007: Port soft_rst_req, input, 1 bit: synchronous single-cycle request to re-pulse the system reset.
- REQ-008: Port sys_rst, output, 1 bit: active-high reset for the clk domain; registered.
- REQ-009: Port sys_rst_n, output, 1 bit: registered complement of sys_rst.
- REQ-010: Port ready, output, 1 bit: high exactly when the FSM is in RUN; registered.
- REQ-011: Port lock_loss_count, output, 8 bits: count of lock-loss events.

Function
- REQ-012: pll_locked SHALL pass through a SYNC_STAGES-deep flop chain clocked by clk; locked_s is the final stage, and no other logic shall sample pll_locked.
- REQ-013: The FSM SHALL have four states, WAIT_LOCK, FILTER, HOLD and RUN, plus one cycle counter cnt of width clog2(max(FILTER_CYCLES,HOLD_CYCLES)), minimum 1.
- REQ-014: In WAIT_LOCK: if locked_s=1, go to FILTER with cnt=0; otherwise stay.
- REQ-015: In FILTER: if locked_s=0, go to WAIT_LOCK; else if cnt=FILTER_CYCLES-1, go to HOLD with cnt=0; else increment cnt.
- REQ-016: In HOLD: if locked_s=0, go to WAIT_LOCK; else if cnt=HOLD_CYCLES-1, go to RUN; else increment cnt.
- REQ-017: In RUN: if locked_s=0, go to WAIT_LOCK (a lock-loss event); else if soft_rst_req=1, go to HOLD with cnt=0; else stay.
- REQ-018: Lock loss SHALL take priority over soft_rst_req when both occur in the same cycle.
- REQ-019: soft_rst_req SHALL be ignored in every state other than RUN.
- REQ-020: sys_rst SHALL be registered as (next_state != RUN), so it changes on the same edge as the state transition; ready = ~sys_rst and sys_rst_n = ~sys_rst.
- REQ-021: Release latency: with pll_locked rising and staying high, sys_rst SHALL fall exactly SYNC_STAGES+FILTER_CYCLES+HOLD_CYCLES+1 clk edges later (275 for the defaults).
- REQ-022: Assert latency: in RUN, sys_rst SHALL rise exactly SYNC_STAGES+1 edges after pll_locked falls.
- REQ-023: A soft reset request SHALL assert sys_rst on the next edge and hold it for exactly HOLD_CYCLES cycles.
- REQ-024: A lock glitch shorter than FILTER_CYCLES (after synchronisation) SHALL never release reset.

Reset
- REQ-025: While rst=1, asynchronously: synchroniser flops=0, state=WAIT_LOCK, cnt=0, sys_rst=1, sys_rst_n=0, ready=0, lock_loss_count=0.
- REQ-026: After rst deasserts mid-sequence, the FSM SHALL restart from WAIT_LOCK; no partial count is retained.
- REQ-027: rst deassertion is not synchronised internally; the upstream source is responsible for meeting recovery timing.

Configuration
- REQ-028: The macro PLL_RESET_SEQ_LOSS_COUNT_EN SHALL control the lock-loss counter.
- REQ-029: With PLL_RESET_SEQ_LOSS_COUNT_EN defined, lock_loss_count SHALL increment by 1 on each RUN-to-WAIT_LOCK transition and saturate at 255.
- REQ-030: Without PLL_RESET_SEQ_LOSS_COUNT_EN, lock_loss_count SHALL be constant 0 and no counter flops shall be inferred; all other behaviour is identical.

Verification (defaults unless stated)
- REQ-031: Scenario 1: rst pulse, then pll_locked=1 held -> sys_rst falls and ready rises at edge 275 after the lock rise; sys_rst_n mirrors sys_rst.
- REQ-032: Scenario 2: pll_locked high for 10 cycles, low for 5, then high -> no release during the glitch; release 275 edges after the final rise.
- REQ-033: Scenario 3: in RUN, drop pll_locked -> sys_rst=1 at edge 3; lock_loss_count goes 0->1 (macro defined) or stays 0 (macro undefined).
- REQ-034: Scenario 4: in RUN, one-cycle soft_rst_req -> sys_rst high for exactly 256 cycles, then RUN; lock_loss_count unchanged.
- REQ-035: Scenario 5: soft_rst_req in the same cycle locked_s falls -> WAIT_LOCK (no return to RUN until lock is re-filtered); count +1.
- REQ-036: Scenario 6: 300 lock-loss events with the macro defined -> lock_loss_count=255; assert rst mid-HOLD -> all outputs return immediately to their reset values.
